// File: rtl/pb_cond_pkg.sv
// Shared types and defaults for the pushbutton conditioner.
// Channel FSM encoding plus the level decode used by every channel.
package pb_cond_pkg;

   localparam int PB_DEBOUNCE_DEFAULT = 10000;
   localparam int PB_HOLD_DEFAULT     = 5000000;

   typedef enum logic [2:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      HELD,
      RELEASE_WAIT
   } pb_state_t;

   function automatic logic pb_level_of(input pb_state_t st);
      return (st == PRESSED) || (st == HELD) || (st == RELEASE_WAIT);
   endfunction

endpackage

// File: rtl/pb_channel.sv
// One pushbutton channel: 2-flop synchronizer, edge debounce, hold timer,
// registered level and single-cycle press/release/hold pulses.
//
//   state        | meaning
//   -------------+-------------------------------------------------------
//   IDLE         | button released and stable, level 0
//   PRESS_WAIT   | pin seen high, counting stable samples, level still 0
//   PRESSED      | press accepted, hold timer running, level 1
//   HELD         | hold pulse already issued for this press, level 1
//   RELEASE_WAIT | pin seen low, counting stable samples, hold timer frozen
module pb_channel
   import pb_cond_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = PB_DEBOUNCE_DEFAULT,
   parameter int HOLD_CYCLES     = PB_HOLD_DEFAULT
) (
   input  logic clk,
   input  logic n_rst,
   input  logic pin,
   output logic lvl,
   output logic press,
   output logic rls,
   output logic hold
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam logic [DW-1:0] DEB_ONE   = DW'(1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   logic          sync_q1;
   logic          s;
   pb_state_t     state_q, state_d;
   logic [DW-1:0] deb_cnt, deb_cnt_d;
   logic [HW-1:0] hold_cnt, hold_cnt_d;
   logic          from_held, from_held_d;
   logic          lvl_d, press_d, rls_d, hold_d;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sync_q1 <= 1'b0;
         s       <= 1'b0;
      end else begin
         sync_q1 <= pin;
         s       <= sync_q1;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q   <= IDLE;
         deb_cnt   <= '0;
         hold_cnt  <= '0;
         from_held <= 1'b0;
         lvl       <= 1'b0;
         press     <= 1'b0;
         rls       <= 1'b0;
         hold      <= 1'b0;
      end else begin
         state_q   <= state_d;
         deb_cnt   <= deb_cnt_d;
         hold_cnt  <= hold_cnt_d;
         from_held <= from_held_d;
         lvl       <= lvl_d;
         press     <= press_d;
         rls       <= rls_d;
         hold      <= hold_d;
      end
   end

   // hold_cnt only advances while below HOLD_LAST, so it can never wrap.
   always_comb begin
      state_d     = state_q;
      deb_cnt_d   = deb_cnt;
      hold_cnt_d  = hold_cnt;
      from_held_d = from_held;
      case (state_q)
         IDLE: begin
            if (s) begin
               state_d   = PRESS_WAIT;
               deb_cnt_d = DEB_ONE;
            end
         end
         PRESS_WAIT: begin
            if (!s) begin
               state_d = IDLE;
            end else if (deb_cnt == DEB_LAST) begin
               state_d    = PRESSED;
               hold_cnt_d = '0;
            end else begin
               deb_cnt_d = deb_cnt + 1'b1;
            end
         end
         PRESSED: begin
            if (!s) begin
               state_d     = RELEASE_WAIT;
               deb_cnt_d   = DEB_ONE;
               from_held_d = 1'b0;
            end else if (hold_cnt == HOLD_LAST) begin
               state_d = HELD;
            end else begin
               hold_cnt_d = hold_cnt + 1'b1;
            end
         end
         HELD: begin
            if (!s) begin
               state_d     = RELEASE_WAIT;
               deb_cnt_d   = DEB_ONE;
               from_held_d = 1'b1;
            end
         end
         RELEASE_WAIT: begin
            // The returning sample is itself a pressed cycle, so a glitch costs
            // the hold timer exactly the number of low samples it contained.
            if (s) begin
               if (from_held) begin
                  state_d = HELD;
               end else if (hold_cnt == HOLD_LAST) begin
                  state_d = HELD;
               end else begin
                  state_d    = PRESSED;
                  hold_cnt_d = hold_cnt + 1'b1;
               end
            end else if (deb_cnt == DEB_LAST) begin
               state_d = IDLE;
            end else begin
               deb_cnt_d = deb_cnt + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      lvl_d   = pb_level_of(state_d);
      press_d = (state_q == PRESS_WAIT) && (state_d == PRESSED);
      rls_d   = (state_q == RELEASE_WAIT) && (state_d == IDLE);
      hold_d  = (state_d == HELD) &&
                ((state_q == PRESSED) || ((state_q == RELEASE_WAIT) && !from_held));
   end

endmodule

// File: rtl/pb_conditioner.sv
// Pushbutton conditioner: NUM_PB independent debounced channels feeding
// the stopwatch core with a clean level and press/release/hold pulses.
module pb_conditioner
   import pb_cond_pkg::*;
#(
   parameter int NUM_PB          = 2,
   parameter int DEBOUNCE_CYCLES = PB_DEBOUNCE_DEFAULT,
   parameter int HOLD_CYCLES     = PB_HOLD_DEFAULT
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic [NUM_PB-1:0] pb_in,
   output logic [NUM_PB-1:0] pb_level,
   output logic [NUM_PB-1:0] pb_press,
   output logic [NUM_PB-1:0] pb_release,
   output logic [NUM_PB-1:0] pb_hold
);

   for (genvar i = 0; i < NUM_PB; i++) begin : g_ch
      pb_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .HOLD_CYCLES     (HOLD_CYCLES)
      ) u_ch (
         .clk   (clk),
         .n_rst (n_rst),
         .pin   (pb_in[i]),
         .lvl   (pb_level[i]),
         .press (pb_press[i]),
         .rls   (pb_release[i]),
         .hold  (pb_hold[i])
      );
   end

endmodule

// File: tb/tb_pb_conditioner.sv
// Bench for pb_conditioner with DEBOUNCE_CYCLES=4, HOLD_CYCLES=20.
// Pin segments come from row tables; pulses are matched against a scoreboard.
module tb_pb_conditioner;

   localparam int NPB = 2;
   localparam int DEB = 4;
   localparam int HLD = 20;

   logic           clk = 1'b0;
   logic           n_rst = 1'b0;
   logic [NPB-1:0] pb_in = '0;
   logic [NPB-1:0] pb_level, pb_press, pb_release, pb_hold;

   pb_conditioner #(
      .NUM_PB          (NPB),
      .DEBOUNCE_CYCLES (DEB),
      .HOLD_CYCLES     (HLD)
   ) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .pb_in      (pb_in),
      .pb_level   (pb_level),
      .pb_press   (pb_press),
      .pb_release (pb_release),
      .pb_hold    (pb_hold)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] pin;
      int         len;
      logic [1:0] lvl;
   } row_t;

   typedef struct {
      int at;
      int ch;
      int kind;
   } ev_t;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   edge_n  = 0;
   int   base    = 0;
   row_t rows[$];
   ev_t  sb_q[$];

   always @(posedge clk) edge_n <= edge_n + 1;

   function automatic string kind_name(input int kind);
      if (kind == 0) return "press";
      if (kind == 1) return "release";
      return "hold";
   endfunction

   task automatic exp_ev(input int off, input int ch, input int kind);
      ev_t e;
      e.at   = base + off;
      e.ch   = ch;
      e.kind = kind;
      sb_q.push_back(e);
   endtask

   task automatic check_pulse(input int ch, input int kind, input logic v);
      int idx;
      if (v) begin
         idx = -1;
         for (int i = 0; i < sb_q.size(); i++)
            if (idx < 0 && sb_q[i].at == edge_n && sb_q[i].ch == ch && sb_q[i].kind == kind)
               idx = i;
         n_tests++;
         if (idx < 0) begin
            n_fail++;
            $display("FAIL pulse_%s[%0d]: got pulse at edge %0d (offset %0d), required none",
                     kind_name(kind), ch, edge_n, edge_n - base);
         end else begin
            sb_q.delete(idx);
         end
      end
   endtask

   always @(posedge clk) begin
      #2;
      for (int ch = 0; ch < NPB; ch++) begin
         check_pulse(ch, 0, pb_press[ch]);
         check_pulse(ch, 1, pb_release[ch]);
         check_pulse(ch, 2, pb_hold[ch]);
      end
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
         if (sb_q[i].at < edge_n) begin
            n_tests++;
            n_fail++;
            $display("FAIL pulse_%s[%0d]: got no pulse, required one at offset %0d",
                     kind_name(sb_q[i].kind), sb_q[i].ch, sb_q[i].at - base);
            sb_q.delete(i);
         end
      end
   end

   task automatic add_row(input logic [1:0] pin, input int len, input logic [1:0] lvl);
      row_t r;
      r.pin = pin;
      r.len = len;
      r.lvl = lvl;
      rows.push_back(r);
   endtask

   task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %b, required %b", name, act, req);
      end
   endtask

   // Called just after a posedge; each row drives its pin value for len edges.
   task automatic run_rows(input string name);
      int off;
      off = 0;
      for (int i = 0; i < rows.size(); i++) begin
         pb_in = rows[i].pin;
         repeat (rows[i].len) @(posedge clk);
         #1;
         off = off + rows[i].len;
         chk2($sformatf("%s_level_row%0d_off%0d", name, i, off), pb_level, rows[i].lvl);
      end
      rows.delete();
      #2;
      for (int i = 0; i < sb_q.size(); i++) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_pending_%s[%0d]: got nothing by scenario end, required pulse at offset %0d",
                  name, kind_name(sb_q[i].kind), sb_q[i].ch, sb_q[i].at - base);
      end
      sb_q.delete();
      @(posedge clk);
      #1;
   endtask

   // Asserts reset asynchronously, checks outputs clear at once, then releases.
   task automatic do_reset(input string name, input logic [1:0] pin);
      pb_in = pin;
      n_rst = 1'b0;
      #1;
      chk2({name, "_rst_level"},   pb_level,   2'b00);
      chk2({name, "_rst_press"},   pb_press,   2'b00);
      chk2({name, "_rst_release"}, pb_release, 2'b00);
      chk2({name, "_rst_hold"},    pb_hold,    2'b00);
      repeat (3) @(posedge clk);
      #1;
      n_rst = 1'b1;
      base  = edge_n;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clk);
      #1;

      // Both pins high through reset: fresh press 5 edges after first sample.
      do_reset("reset", 2'b11);
      exp_ev(6, 0, 0);
      exp_ev(6, 1, 0);
      add_row(2'b11, 5, 2'b00);
      add_row(2'b11, 3, 2'b11);
      run_rows("reset");

      // Clean press and release on channel 0.
      do_reset("clean", 2'b00);
      exp_ev(8, 0, 0);
      exp_ev(23, 0, 1);
      add_row(2'b00, 2, 2'b00);
      add_row(2'b01, 15, 2'b01);
      add_row(2'b00, 4, 2'b01);
      add_row(2'b00, 6, 2'b00);
      run_rows("clean");

      // Bounce on channel 1 is rejected, then a solid press is accepted.
      do_reset("bounce", 2'b00);
      exp_ev(19, 1, 0);
      add_row(2'b00, 1, 2'b00);
      add_row(2'b10, 3, 2'b00);
      add_row(2'b00, 1, 2'b00);
      add_row(2'b10, 2, 2'b00);
      add_row(2'b00, 6, 2'b00);
      add_row(2'b10, 5, 2'b00);
      add_row(2'b10, 5, 2'b10);
      run_rows("bounce");

      // Long hold with a 2-cycle low glitch: hold slips from offset 27 to 29.
      do_reset("hold", 2'b00);
      exp_ev(7, 0, 0);
      exp_ev(29, 0, 2);
      add_row(2'b00, 1, 2'b00);
      add_row(2'b01, 12, 2'b01);
      add_row(2'b00, 2, 2'b01);
      add_row(2'b01, 13, 2'b01);
      add_row(2'b01, 12, 2'b01);
      run_rows("hold");

      // Reset while HELD with the button still down: re-debounce and re-hold.
      do_reset("midrst", 2'b01);
      exp_ev(6, 0, 0);
      exp_ev(26, 0, 2);
      add_row(2'b01, 5, 2'b00);
      add_row(2'b01, 23, 2'b01);
      run_rows("midrst");

      // Both pressed together; releasing channel 0 leaves channel 1 untouched.
      do_reset("indep", 2'b00);
      exp_ev(7, 0, 0);
      exp_ev(7, 1, 0);
      exp_ev(17, 0, 1);
      exp_ev(27, 1, 2);
      add_row(2'b00, 1, 2'b00);
      add_row(2'b11, 10, 2'b11);
      add_row(2'b10, 10, 2'b10);
      add_row(2'b10, 10, 2'b10);
      run_rows("indep");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
